// File: rtl/theatre_control.sv
// Purpose: theatre lighting/AV mode controller with sensor-tracked spotlight.
// Latency: mode/EN to outputs 1 clk; stage sensor to S1 SYNC_STAGES+1 clks.
// Backpressure: none; outputs are free-running registered levels.
module theatre_control #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EN,
    input  logic       House,
    input  logic       Music,
    input  logic       Speaker,
    input  logic       Play,
    input  logic       TL,
    input  logic       TC,
    input  logic       TR,
    output logic       HL,
    output logic       VD,
    output logic [2:0] S1
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_HOUSE,
        ST_MUSIC,
        ST_SPEAKER,
        ST_PLAY
    } state_t;

    localparam logic [2:0] POS_LEFT   = 3'b100;
    localparam logic [2:0] POS_CENTRE = 3'b010;
    localparam logic [2:0] POS_RIGHT  = 3'b001;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [2:0]             r_pos;
    logic [2:0]             w_pos_next;
    logic                   w_hl_next;
    logic                   w_vd_next;
    logic [2:0]             w_s1_next;
    logic                   w_track;
    logic [SYNC_STAGES-1:0] r_sync_l;
    logic [SYNC_STAGES-1:0] r_sync_c;
    logic [SYNC_STAGES-1:0] r_sync_r;
    logic                   w_l;
    logic                   w_c;
    logic                   w_r;

    // Sensor synchronisers; idle level (1) on reset so nothing looks touched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_l <= '1;
            r_sync_c <= '1;
            r_sync_r <= '1;
        end else begin
            r_sync_l <= {r_sync_l[SYNC_STAGES-2:0], TL};
            r_sync_c <= {r_sync_c[SYNC_STAGES-2:0], TC};
            r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], TR};
        end
    end

    // Sensors are active-low; invert after synchronising.
    assign w_l = ~r_sync_l[SYNC_STAGES-1];
    assign w_c = ~r_sync_c[SYNC_STAGES-1];
    assign w_r = ~r_sync_r[SYNC_STAGES-1];

    // Next state, next spotlight position and next output values.
    always_comb begin
        w_next_state = ST_OFF;
        w_pos_next   = r_pos;
        w_hl_next    = 1'b0;
        w_vd_next    = 1'b0;
        w_s1_next    = 3'b000;

        if (EN) begin
            if (House)        w_next_state = ST_HOUSE;
            else if (Music)   w_next_state = ST_MUSIC;
            else if (Speaker) w_next_state = ST_SPEAKER;
            else if (Play)    w_next_state = ST_PLAY;
        end

        w_track = (w_next_state == ST_SPEAKER) || (w_next_state == ST_PLAY);

        // Fresh entry parks the spot at centre; tracking begins next edge.
        if (w_track) begin
            if (r_state != w_next_state) w_pos_next = POS_CENTRE;
            else if (w_l)                w_pos_next = POS_LEFT;
            else if (w_c)                w_pos_next = POS_CENTRE;
            else if (w_r)                w_pos_next = POS_RIGHT;
            else                         w_pos_next = POS_CENTRE;
        end

        case (w_next_state)
            ST_HOUSE:   w_hl_next = 1'b1;
            ST_MUSIC:   w_s1_next = 3'b111;
            ST_SPEAKER: begin
                w_vd_next = 1'b1;
                w_s1_next = w_pos_next;
            end
            ST_PLAY:    w_s1_next = w_pos_next;
            default:    ;
        endcase
    end

    // State, position and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_pos   <= POS_CENTRE;
            HL      <= 1'b0;
            VD      <= 1'b0;
            S1      <= 3'b000;
        end else begin
            r_state <= w_next_state;
            r_pos   <= w_pos_next;
            HL      <= w_hl_next;
            VD      <= w_vd_next;
            S1      <= w_s1_next;
        end
    end

endmodule

// File: tb/tb_theatre_control.sv
// Bench for theatre_control: directed scenarios with literal expectations,
// then randomized mode/sensor/reset traffic checked every cycle against a
// behavioural model (sensor history queue + mode/position rules).
module tb_theatre_control;

    localparam int SS = 2;

    logic       clk;
    logic       reset;
    logic       EN, House, Music, Speaker, Play;
    logic       TL, TC, TR;
    logic       HL, VD;
    logic [2:0] S1;

    int checks;
    int failures;

    // Model: mode 0=off 1=house 2=music 3=speaker 4=play
    int         m_mode;
    logic [2:0] m_pos;
    logic [2:0] m_hist[$];

    theatre_control #(.SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset   (reset),
        .EN      (EN),
        .House   (House),
        .Music   (Music),
        .Speaker (Speaker),
        .Play    (Play),
        .TL      (TL),
        .TC      (TC),
        .TR      (TR),
        .HL      (HL),
        .VD      (VD),
        .S1      (S1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={HL,VD,S1}=%b expected=%b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [4:0] exp);
        chk(nm, {HL, VD, S1}, exp);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 3'b010;
        m_hist.delete();
    endtask

    function automatic int req_mode();
        if (!EN)     return 0;
        if (House)   return 1;
        if (Music)   return 2;
        if (Speaker) return 3;
        if (Play)    return 4;
        return 0;
    endfunction

    // Active-low sensor triple {TL,TC,TR} to spotlight position.
    function automatic logic [2:0] resolve(input logic [2:0] s);
        if (!s[2]) return 3'b100;
        if (!s[1]) return 3'b010;
        if (!s[0]) return 3'b001;
        return 3'b010;
    endfunction

    // One clock edge of the model: the controller sees the sensor level
    // that was present SS edges earlier (idle before that).
    task automatic model_edge();
        logic [2:0] seen;
        int         nm;
        seen = (m_hist.size() >= SS) ? m_hist[m_hist.size() - SS] : 3'b111;
        m_hist.push_back({TL, TC, TR});
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        nm = req_mode();
        if (nm >= 3) m_pos = (nm != m_mode) ? 3'b010 : resolve(seen);
        m_mode = nm;
    endtask

    function automatic logic [4:0] model_out();
        logic [2:0] s;
        s = 3'b000;
        if (m_mode == 2) s = 3'b111;
        else if (m_mode >= 3) s = m_pos;
        return {(m_mode == 1), (m_mode == 3), s};
    endfunction

    // Advance one clock; compare against the model on the falling edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!reset) model_edge();
            @(negedge clk);
            chk("model", {HL, VD, S1}, model_out());
        end
    endtask

    // Reset pulse of one clock period starting at a falling edge.
    task automatic pulse_reset(input string nm);
        reset = 1'b1;
        #1;
        lit(nm, 5'b00000);
        model_reset();
        @(negedge clk);
        lit(nm, 5'b00000);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset = 1'b1;
        EN = 0; House = 0; Music = 0; Speaker = 0; Play = 0;
        TL = 1; TC = 1; TR = 1;
        #2;
        lit("t1_in_reset", 5'b00000);
        @(negedge clk);
        reset = 1'b0;

        // 1: disabled, then enabled without a mode
        step(2);
        lit("t1_off", 5'b00000);
        EN = 1;
        step(2);
        lit("t1_en_nomode", 5'b00000);

        // 2: house then music
        House = 1;
        step(1);
        lit("t2_house", 5'b10000);
        House = 0; Music = 1;
        step(1);
        lit("t2_music", 5'b00111);

        // 3: speaker sweep
        Music = 0; Speaker = 1;
        step(1);
        lit("t3_speaker_entry", 5'b01010);
        TL = 0;
        step(2);
        lit("t3_left_not_yet", 5'b01010);
        step(1);
        lit("t3_left", 5'b01100);
        TL = 1; TC = 0;
        step(3);
        lit("t3_centre", 5'b01010);
        TC = 1; TR = 0;
        step(3);
        lit("t3_right", 5'b01001);
        TR = 1;
        step(3);
        lit("t3_idle", 5'b01010);

        // 4: play sweep, then reset mid-mode
        Speaker = 0; Play = 1;
        step(1);
        lit("t4_play_entry", 5'b00010);
        TL = 0;
        step(3);
        lit("t4_left", 5'b00100);
        TL = 1; TC = 0;
        step(3);
        lit("t4_centre", 5'b00010);
        TC = 1; TR = 0;
        step(3);
        lit("t4_right", 5'b00001);
        TR = 1;
        step(3);
        lit("t4_idle", 5'b00010);
        TR = 0;
        step(3);
        lit("t4_right_again", 5'b00001);
        pulse_reset("t4_reset_now");
        step(1);
        lit("t4_after_reset", 5'b00010);
        TR = 1;

        // 5: play toggle, EN drop with a sensor held
        step(3);
        Play = 0;
        step(1);
        lit("t5_off_window", 5'b00000);
        Play = 1;
        step(1);
        lit("t5_play_again", 5'b00010);
        TL = 0;
        step(3);
        lit("t5_left", 5'b00100);
        EN = 0;
        step(1);
        lit("t5_en_low", 5'b00000);
        step(3);
        lit("t5_en_low_hold", 5'b00000);

        // 6: priority checks
        EN = 1; House = 1; Play = 1;
        step(1);
        lit("t6_house_wins", 5'b10000);
        House = 0; Play = 0; Speaker = 1; TR = 0;
        step(1);
        lit("t6_speaker_entry", 5'b01010);
        step(3);
        lit("t6_left_over_right", 5'b01100);
        TL = 1; TR = 1; Speaker = 0;
        step(3);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                EN      = ($urandom_range(7) != 0);
                House   = ($urandom_range(5) == 0);
                Music   = ($urandom_range(4) == 0);
                Speaker = ($urandom_range(2) == 0);
                Play    = ($urandom_range(2) == 0);
            end
            if ($urandom_range(3) == 0) begin
                TL = ($urandom_range(9) < 7);
                TC = ($urandom_range(9) < 7);
                TR = ($urandom_range(9) < 7);
            end
            if ($urandom_range(399) == 0) pulse_reset("rand_reset");
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
